// File: rtl/quad_sched_pkg.sv
// Shared types and defaults for the time-multiplexed quadrature decode scheduler.
package quad_sched_pkg;

   localparam int N_CH_DEF  = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      CLR_IDLE,
      CLR_PEND,
      CLR_ACKW
   } clr_state_t;

   // Per-channel decode state; the count lives in a separate array because
   // its width is a module parameter.
   typedef struct packed {
      logic pa;
      logic pb;
      logic primed;
      logic err;
   } ch_state_t;

endpackage

// File: rtl/quad_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; output lags input by two clk edges.
module quad_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/quad_rr_sched.sv
// N_CH quadrature decoders sharing one read-modify-write datapath, one channel per clock.
// Registered host read port (1-cycle latency) and a level req / pulse ack channel clear.
module quad_rr_sched
   import quad_sched_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int CH_W  = $clog2(N_CH),
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  quad_a,
   input  logic [N_CH-1:0]  quad_b,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             clr_req,
   input  logic [CH_W-1:0]  clr_ch,
   output logic             clr_ack,
   input  logic [CH_W-1:0]  rd_ch,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_err,
   output logic [N_CH-1:0]  err,
   output logic [CH_W-1:0]  cur_slot
);

   logic [N_CH-1:0]  w_sa;
   logic [N_CH-1:0]  w_sb;
   logic [CH_W-1:0]  r_slot;
   ch_state_t        r_st  [N_CH];
   logic [CNT_W-1:0] r_cnt [N_CH];
   clr_state_t       r_clr_st;
   clr_state_t       w_clr_nxt;
   logic [CH_W-1:0]  r_clr_ch;
   logic             r_clr_ack;
   logic             w_clr_hit;
   logic             w_clr_lat;
   logic [CNT_W-1:0] r_rd_data;
   logic             r_rd_err;
   ch_state_t        w_cur;
   ch_state_t        w_nxt;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic             w_sa_k;
   logic             w_sb_k;
   logic             w_ce;
   logic             w_dir;

   quad_sync2 #(.W(N_CH)) u_sync_a (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (quad_a),
      .o_q   (w_sa)
   );

   quad_sync2 #(.W(N_CH)) u_sync_b (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (quad_b),
      .o_q   (w_sb)
   );

   assign w_cur  = r_st[r_slot];
   assign w_sa_k = w_sa[r_slot];
   assign w_sb_k = w_sb[r_slot];
   assign w_ce   = w_sa_k ^ w_cur.pa ^ w_sb_k ^ w_cur.pb;
   assign w_dir  = w_sa_k ^ w_cur.pb;

   always_comb begin
      w_clr_nxt = r_clr_st;
      w_clr_hit = 1'b0;
      w_clr_lat = 1'b0;
      case (r_clr_st)
         CLR_IDLE: begin
            if (clr_req) begin
               w_clr_lat = 1'b1;
               w_clr_nxt = CLR_PEND;
            end
         end
         CLR_PEND: begin
            if (r_slot == r_clr_ch) begin
               w_clr_hit = 1'b1;
               w_clr_nxt = CLR_ACKW;
            end
         end
         CLR_ACKW: begin
            if (!clr_req) w_clr_nxt = CLR_IDLE;
         end
         default: w_clr_nxt = CLR_IDLE;
      endcase
   end

   // Unprimed or disabled channels only track the pins, so re-enable never jumps.
   always_comb begin
      w_nxt     = w_cur;
      w_nxt_cnt = r_cnt[r_slot];
      if (!w_cur.primed || !ch_en[r_slot]) begin
         w_nxt.pa     = w_sa_k;
         w_nxt.pb     = w_sb_k;
         w_nxt.primed = ch_en[r_slot];
      end else if ((w_sa_k != w_cur.pa) && (w_sb_k != w_cur.pb)) begin
         w_nxt.pa  = w_sa_k;
         w_nxt.pb  = w_sb_k;
         w_nxt.err = 1'b1;
      end else if (w_ce) begin
         w_nxt.pa  = w_sa_k;
         w_nxt.pb  = w_sb_k;
         w_nxt_cnt = w_dir ? r_cnt[r_slot] + CNT_W'(1) : r_cnt[r_slot] - CNT_W'(1);
      end
      if (w_clr_hit) begin
         w_nxt_cnt    = '0;
         w_nxt.err    = 1'b0;
         w_nxt.primed = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot    <= '0;
         r_clr_st  <= CLR_IDLE;
         r_clr_ch  <= '0;
         r_clr_ack <= 1'b0;
         r_rd_data <= '0;
         r_rd_err  <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_st[i]  <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         r_slot        <= (r_slot == CH_W'(N_CH - 1)) ? '0 : r_slot + CH_W'(1);
         r_clr_st      <= w_clr_nxt;
         r_clr_ack     <= w_clr_hit;
         r_st[r_slot]  <= w_nxt;
         r_cnt[r_slot] <= w_nxt_cnt;
         r_rd_data     <= r_cnt[rd_ch];
         r_rd_err      <= r_st[rd_ch].err;
         if (w_clr_lat) r_clr_ch <= clr_ch;
      end
   end

   always_comb begin
      err = '0;
      for (int i = 0; i < N_CH; i++) err[i] = r_st[i].err;
   end

   assign clr_ack  = r_clr_ack;
   assign rd_data  = r_rd_data;
   assign rd_err   = r_rd_err;
   assign cur_slot = r_slot;

endmodule

// File: tb/tb_quad_rr_sched.sv
// Directed self-checking bench for quad_rr_sched with N_CH=4, CNT_W=8.
module tb_quad_rr_sched;

   logic       clk;
   logic       rst_n;
   logic [3:0] quad_a;
   logic [3:0] quad_b;
   logic [3:0] ch_en;
   logic       clr_req;
   logic [1:0] clr_ch;
   logic       clr_ack;
   logic [1:0] rd_ch;
   logic [7:0] rd_data;
   logic       rd_err;
   logic [3:0] err;
   logic [1:0] cur_slot;

   int n_chk;
   int n_err;
   int ph [4];

   quad_rr_sched #(.N_CH(4), .CH_W(2), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .quad_a   (quad_a),
      .quad_b   (quad_b),
      .ch_en    (ch_en),
      .clr_req  (clr_req),
      .clr_ch   (clr_ch),
      .clr_ack  (clr_ack),
      .rd_ch    (rd_ch),
      .rd_data  (rd_data),
      .rd_err   (rd_err),
      .err      (err),
      .cur_slot (cur_slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Gray phase index 0..3 maps to AB = 00,10,11,01 (forward order).
   task automatic apply_pins(input int ch);
      quad_a[ch] = (ph[ch] == 1) || (ph[ch] == 2);
      quad_b[ch] = (ph[ch] == 2) || (ph[ch] == 3);
   endtask

   task automatic fwd(input int ch);
      ph[ch] = (ph[ch] + 1) % 4;
      apply_pins(ch);
      repeat (8) @(negedge clk);
   endtask

   task automatic rev(input int ch);
      ph[ch] = (ph[ch] + 3) % 4;
      apply_pins(ch);
      repeat (8) @(negedge clk);
   endtask

   task automatic rd(input int ch, output logic [7:0] d, output logic e);
      rd_ch = 2'(ch);
      @(posedge clk);
      @(negedge clk);
      d = rd_data;
      e = rd_err;
   endtask

   task automatic wait_ack(input int lim, output logic found);
      found = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (clr_ack) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       e;
      logic       found;
      int         acks;

      n_chk   = 0;
      n_err   = 0;
      for (int i = 0; i < 4; i++) ph[i] = 0;
      rst_n   = 1'b0;
      quad_a  = '0;
      quad_b  = '0;
      ch_en   = 4'hF;
      clr_req = 1'b0;
      clr_ch  = '0;
      rd_ch   = '0;

      repeat (3) @(negedge clk);
      check_eq("rst_rd_data", 32'(rd_data), 32'h0);
      check_eq("rst_rd_err", 32'(rd_err), 32'h0);
      check_eq("rst_err", 32'(err), 32'h0);
      check_eq("rst_clr_ack", 32'(clr_ack), 32'h0);
      check_eq("rst_slot", 32'(cur_slot), 32'h0);

      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("slot_seq", 32'(cur_slot), 32'(k % 4));
      end
      repeat (8) @(negedge clk);

      // Channel 0 forward one full cycle, then back.
      for (int i = 0; i < 4; i++) fwd(0);
      rd(0, d, e);
      check_eq("ch0_fwd4", 32'(d), 32'h04);
      check_eq("ch0_fwd4_err", 32'(err), 32'h0);
      for (int i = 0; i < 4; i++) rev(0);
      rd(0, d, e);
      check_eq("ch0_rev4", 32'(d), 32'h00);

      // Channel 1 wraps down then up.
      rev(1);
      rd(1, d, e);
      check_eq("ch1_wrap_dn", 32'(d), 32'hFF);
      fwd(1);
      rd(1, d, e);
      check_eq("ch1_wrap_up", 32'(d), 32'h00);
      for (int i = 0; i < 256; i++) fwd(1);
      rd(1, d, e);
      check_eq("ch1_fwd257", 32'(d), 32'h00);
      check_eq("ch1_err", 32'(err), 32'h0);

      // Channel 2 double transition.
      ph[2] = 2;
      apply_pins(2);
      repeat (8) @(negedge clk);
      check_eq("ch2_dbl_err", 32'(err), 32'h4);
      rd(2, d, e);
      check_eq("ch2_dbl_cnt", 32'(d), 32'h00);
      check_eq("ch2_dbl_rd_err", 32'(e), 32'h1);
      rd(0, d, e);
      check_eq("ch0_rd_err_clean", 32'(e), 32'h0);

      // Channel 3 to 5, clear while it moves.
      for (int i = 0; i < 5; i++) fwd(3);
      rd(3, d, e);
      check_eq("ch3_pre_clr", 32'(d), 32'h05);
      clr_ch  = 2'd3;
      clr_req = 1'b1;
      ph[3]   = (ph[3] + 1) % 4;
      apply_pins(3);
      wait_ack(5, found);
      check_eq("ch3_ack_seen", 32'(found), 32'h1);
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (clr_ack) acks++;
      end
      check_eq("ch3_no_2nd_ack", 32'(acks), 32'h0);
      rd(3, d, e);
      check_eq("ch3_clr_cnt", 32'(d), 32'h00);
      check_eq("ch3_clr_err", 32'(err[3]), 32'h0);
      clr_req = 1'b0;
      repeat (2) @(negedge clk);
      fwd(3);
      rd(3, d, e);
      check_eq("ch3_post_clr_step", 32'(d), 32'h01);

      // Clear ch2 after re-raising the request: sticky error must drop.
      clr_ch  = 2'd2;
      clr_req = 1'b1;
      wait_ack(5, found);
      check_eq("ch2_ack_seen", 32'(found), 32'h1);
      @(negedge clk);
      check_eq("ch2_clr_err", 32'(err), 32'h0);
      clr_req = 1'b0;
      rd(2, d, e);
      check_eq("ch2_clr_rd_err", 32'(e), 32'h0);

      // Channel 0 disable / re-enable.
      ch_en[0] = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) fwd(0);
      rd(0, d, e);
      check_eq("ch0_dis_frozen", 32'(d), 32'h00);
      ch_en[0] = 1'b1;
      repeat (8) @(negedge clk);
      rd(0, d, e);
      check_eq("ch0_reen_nojump", 32'(d), 32'h00);
      fwd(0);
      rd(0, d, e);
      check_eq("ch0_reen_step", 32'(d), 32'h01);

      // Reset with a clear pending.
      clr_ch  = 2'd1;
      clr_req = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_err", 32'(err), 32'h0);
      check_eq("mrst_ack", 32'(clr_ack), 32'h0);
      check_eq("mrst_slot", 32'(cur_slot), 32'h0);
      check_eq("mrst_rd_data", 32'(rd_data), 32'h0);
      clr_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (clr_ack) acks++;
      end
      check_eq("mrst_no_ack", 32'(acks), 32'h0);
      check_eq("mrst_err_after", 32'(err), 32'h0);
      for (int c = 0; c < 4; c++) begin
         rd(c, d, e);
         check_eq("mrst_cnt", 32'(d), 32'h00);
      end
      fwd(0);
      rd(0, d, e);
      check_eq("mrst_ch0_step", 32'(d), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
